// File: rtl/pulse_gate_n.sv
// Gates N transition-encoded pulse channels into one transition-encoded output on each readout.
// The output toggle lands OUT_DLY cycles after the readout. There is no backpressure; violations are flagged and counted.
module pulse_gate_n #(
  parameter int N        = 2,
  parameter int MODE     = 0,
  parameter int INIT_CYC = 8,
  parameter int OUT_DLY  = 5,
  parameter int HOLD_CYC = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic         rd,
  output logic         out,
  output logic         ready,
  output logic         busy,
  output logic         viol,
  output logic [7:0]   viol_cnt
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_init_cnt, w_init_cnt_nxt;
  logic [N-1:0]       r_a, r_flag, w_flag_nxt, w_flag_base, w_a_pls, w_a_act;
  logic               r_rd, w_rd_pls, w_fire, w_result, w_viol;
  logic [OUT_DLY-1:0] r_dly, w_dly_nxt;
  logic [3:0]         r_hold, w_hold_nxt;
  logic               r_out, r_viol;
  logic [7:0]         r_viol_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= 8'(INIT_CYC);
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt <= 8'd1) begin
          w_state_nxt    = ST_RUN;
          w_init_cnt_nxt = 8'd0;
        end else begin
          w_init_cnt_nxt = r_init_cnt - 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign w_a_pls  = a ^ r_a;
  assign w_rd_pls = rd ^ r_rd;
  assign w_fire   = (r_state == ST_RUN) && w_rd_pls;
  assign w_a_act  = (r_state == ST_RUN) ? w_a_pls : '0;

  always_comb begin
    case (MODE)
      0:       w_result = ^r_flag;
      1:       w_result = |r_flag;
      default: w_result = &r_flag;
    endcase
  end

  // A readout samples the old flags; a same-cycle data pulse lands on the cleared set.
  always_comb begin
    w_flag_base = w_fire ? '0 : r_flag;
    w_flag_nxt  = (MODE == 0) ? (w_flag_base ^ w_a_act) : (w_flag_base | w_a_act);
    w_viol      = ((MODE != 0) && (|(w_a_act & w_flag_base)))
                || ((|w_a_act) && (r_hold != 4'd0))
                || (w_fire && (|w_a_act) && (HOLD_CYC > 0));
  end

  always_comb begin
    w_hold_nxt = (r_hold != 4'd0) ? (r_hold - 4'd1) : 4'd0;
    if (w_fire)
      w_hold_nxt = 4'(HOLD_CYC);
  end

  always_comb begin
    w_dly_nxt    = r_dly << 1;
    w_dly_nxt[0] = w_fire & w_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_rd       <= 1'b0;
      r_flag     <= '0;
      r_dly      <= '0;
      r_hold     <= 4'd0;
      r_out      <= 1'b0;
      r_viol     <= 1'b0;
      r_viol_cnt <= 8'd0;
    end else begin
      r_a    <= a;
      r_rd   <= rd;
      r_flag <= w_flag_nxt;
      r_dly  <= w_dly_nxt;
      r_hold <= w_hold_nxt;
      r_out  <= r_out ^ r_dly[OUT_DLY-1];
      r_viol <= w_viol;
      if (w_viol && (r_viol_cnt != 8'hFF))
        r_viol_cnt <= r_viol_cnt + 8'd1;
    end
  end

  assign out      = r_out;
  assign ready    = (r_state == ST_RUN);
  assign busy     = |r_flag;
  assign viol     = r_viol;
  assign viol_cnt = r_viol_cnt;

endmodule

// File: tb/tb_pulse_gate_n.sv
// Drives one stimulus stream into XOR, OR and AND instances of pulse_gate_n.
// Expected out toggles are queued at readout time and retired as their cycle arrives.
module tb_pulse_gate_n;

  localparam int OUT_DLY = 5;

  typedef struct {
    int cyc;
    int idx;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] a = 2'b00;
  logic       rd = 1'b0;

  logic       out_w [3];
  logic       rdy_w [3];
  logic       busy_w[3];
  logic       viol_w[3];
  logic [7:0] vc_w  [3];

  ev_t  sb[$];
  logic exp_out[3];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pulse_gate_n #(.N(2), .MODE(0), .INIT_CYC(8), .OUT_DLY(OUT_DLY), .HOLD_CYC(2)) u0 (
    .clk(clk), .rst_n(rst_n), .a(a), .rd(rd), .out(out_w[0]), .ready(rdy_w[0]),
    .busy(busy_w[0]), .viol(viol_w[0]), .viol_cnt(vc_w[0]));
  pulse_gate_n #(.N(2), .MODE(1), .INIT_CYC(8), .OUT_DLY(OUT_DLY), .HOLD_CYC(2)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a), .rd(rd), .out(out_w[1]), .ready(rdy_w[1]),
    .busy(busy_w[1]), .viol(viol_w[1]), .viol_cnt(vc_w[1]));
  pulse_gate_n #(.N(2), .MODE(2), .INIT_CYC(8), .OUT_DLY(OUT_DLY), .HOLD_CYC(2)) u2 (
    .clk(clk), .rst_n(rst_n), .a(a), .rd(rd), .out(out_w[2]), .ready(rdy_w[2]),
    .busy(busy_w[2]), .viol(viol_w[2]), .viol_cnt(vc_w[2]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_rdy, input logic e_busy,
                         input logic e_viol, input logic [7:0] e_cnt);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.ready.u%0d", tag, i), {7'd0, rdy_w[i]}, {7'd0, e_rdy});
      chk($sformatf("%s.busy.u%0d", tag, i), {7'd0, busy_w[i]}, {7'd0, e_busy});
      chk($sformatf("%s.viol.u%0d", tag, i), {7'd0, viol_w[i]}, {7'd0, e_viol});
      chk($sformatf("%s.viol_cnt.u%0d", tag, i), vc_w[i], e_cnt);
    end
  endtask

  // One clock; retire due toggles, then check every out against the model.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_out[sb[0].idx] = ~exp_out[sb[0].idx];
      void'(sb.pop_front());
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("out.u%0d@%0d", i, cyc), {7'd0, out_w[i]}, {7'd0, exp_out[i]});
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // res[i] is the gate result expected from instance i for this readout.
  task automatic rd_pulse(input logic [2:0] res);
    ev_t e;
    rd = ~rd;
    for (int i = 0; i < 3; i++) begin
      if (res[i]) begin
        e.cyc = cyc + 1 + OUT_DLY;
        e.idx = i;
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) exp_out[i] = 1'b0;

    // Level held through reset release, then a toggle inside INIT.
    a = 2'b01;
    ticks(2);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    ticks(3);
    a = 2'b11;
    ticks(4);
    chk_all("init7", 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    chk_all("init8", 1'b1, 1'b0, 1'b0, 8'd0);

    // Single a[0] pulse, readout 4 cycles later.
    ticks(2);
    a ^= 2'b01;
    tick();
    chk_all("a0_set", 1'b1, 1'b1, 1'b0, 8'd0);
    ticks(3);
    rd_pulse(3'b011);
    tick();
    chk_all("rd_clr", 1'b1, 1'b0, 1'b0, 8'd0);
    ticks(7);

    // Both channels pulsed: parity 0, OR 1, AND 1.
    a ^= 2'b11;
    tick();
    chk_all("both_set", 1'b1, 1'b1, 1'b0, 8'd0);
    ticks(3);
    rd_pulse(3'b110);
    tick();
    ticks(7);
    chk_all("par_done", 1'b1, 1'b0, 1'b0, 8'd0);

    // Empty readout still opens the hold window.
    rd_pulse(3'b000);
    tick();
    a ^= 2'b01;
    tick();
    chk_all("hold_viol", 1'b1, 1'b1, 1'b1, 8'd1);
    tick();
    chk_all("viol_1cyc", 1'b1, 1'b1, 1'b0, 8'd1);

    // Same-cycle a[1] pulse and readout of flags {0,1}.
    ticks(3);
    a ^= 2'b10;
    rd_pulse(3'b011);
    tick();
    chk_all("same_cyc", 1'b1, 1'b1, 1'b1, 8'd2);
    ticks(7);

    // Reset while a result-1 toggle is in flight.
    rd_pulse(3'b011);
    ticks(3);
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) exp_out[i] = 1'b0;
    #1;
    chk_all("mid_rst", 1'b0, 1'b0, 1'b0, 8'd0);
    ticks(3);
    rst_n = 1'b1;
    ticks(8);
    chk_all("rst_rel", 1'b1, 1'b0, 1'b0, 8'd0);
    ticks(4);

    // Repeated a[0] pulses: duplicates in OR/AND saturate the counter.
    for (int k = 1; k <= 300; k++) begin
      a ^= 2'b01;
      tick();
      if (k == 255) begin
        chk("sat254.u0", vc_w[0], 8'd0);
        chk("sat254.u1", vc_w[1], 8'd254);
        chk("sat254.u2", vc_w[2], 8'd254);
      end
    end
    chk("sat.u0", vc_w[0], 8'd0);
    chk("sat.u1", vc_w[1], 8'd255);
    chk("sat.u2", vc_w[2], 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
